// File: rtl/mat_pkg.sv
// mat_pkg: shared widths, default sync marker and FSM state encoding for frame_loader.
package mat_pkg;
   localparam int MAT_ELEMS = 9;
   localparam int DATA_W = 8;
   localparam int IDX_W = $clog2(MAT_ELEMS);
   localparam logic [DATA_W-1:0] SYNC_BYTE_DEF = 8'hA5;
   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD_A = 3'd1, S_LOAD_B = 3'd2, S_CHECK = 3'd3, S_DONE = 3'd4;
   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_LOAD_A = S_LOAD_A,
      ST_LOAD_B = S_LOAD_B,
      ST_CHECK  = S_CHECK,
      ST_DONE   = S_DONE
   } state_e;
endpackage

// File: rtl/frame_loader_if.sv
// frame_loader_if: byte input, downstream handshake and matrix-pair outputs of frame_loader.
interface frame_loader_if;
   import mat_pkg::*;
   logic [DATA_W-1:0] i_data;
   logic              i_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_mat_a [MAT_ELEMS];
   logic [DATA_W-1:0] o_mat_b [MAT_ELEMS];
   logic              o_valid;
   logic              o_busy;
   logic              o_err;
   logic              o_overrun;
   modport master (output i_data, i_valid, i_ready,
                   input  o_mat_a, o_mat_b, o_valid, o_busy, o_err, o_overrun);
   modport slave  (input  i_data, i_valid, i_ready,
                   output o_mat_a, o_mat_b, o_valid, o_busy, o_err, o_overrun);
endinterface

// File: rtl/idle_timer.sv
// idle_timer: counts enabled cycles since the last clear and flags expiry at TIMEOUT_CYC-1.
module idle_timer #(
   parameter int unsigned TIMEOUT_CYC = 1200000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);
   localparam int W = $clog2(TIMEOUT_CYC + 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign cnt_d = (i_clear || !i_enable) ? '0 : cnt_q + 1'b1;
   assign o_expired = i_enable && cnt_q == W'(TIMEOUT_CYC - 1);
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/frame_loader.sv
// frame_loader: assembles sync + 18-byte matrix-pair frames from a UART byte stream.
// Define FRAME_CHECKSUM_EN to append and verify a trailing XOR checksum byte (CHECK state).
module frame_loader
   import mat_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYC = 1200000,
   parameter logic [DATA_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
   input logic           i_clk,
   input logic           i_rst,
   frame_loader_if.slave bus
);
`ifdef FRAME_CHECKSUM_EN
   localparam state_e AFTER_B = ST_CHECK;
`else
   localparam state_e AFTER_B = ST_DONE;
`endif
   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] mat_a_q [MAT_ELEMS];
   logic [DATA_W-1:0] mat_b_q [MAT_ELEMS];
   logic              valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
   logic              loading, expired, last, sync;
   assign loading = state_q inside {ST_LOAD_A, ST_LOAD_B, ST_CHECK};
   assign last    = idx_q == IDX_W'(MAT_ELEMS - 1);
   assign sync    = bus.i_valid && bus.i_data == SYNC_BYTE;
   idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .i_clk,
      .i_rst,
      .i_clear  (bus.i_valid || state_d != state_q),
      .i_enable (loading),
      .o_expired(expired)
   );
`ifdef FRAME_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
   logic              csum_ok;
   assign csum_ok = bus.i_data == csum_q;
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) csum_q <= '0;
      else if (state_q inside {ST_LOAD_A, ST_LOAD_B}) csum_q <= bus.i_valid ? csum_q ^ bus.i_data : csum_q;
      else if (state_q != ST_CHECK) csum_q <= '0;
`endif
   // Leaving DONE with i_ready high behaves exactly like IDLE for the same byte.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            ovr_d = state_q == ST_DONE && bus.i_valid && !bus.i_ready;
            if (state_q == ST_IDLE || bus.i_ready) begin
               state_d = sync ? ST_LOAD_A : ST_IDLE;
               idx_d   = '0;
               valid_d = 1'b0;
            end
         end
         ST_LOAD_A, ST_LOAD_B: begin
            if (bus.i_valid) begin
               idx_d   = last ? '0 : idx_q + 1'b1;
               state_d = !last ? state_q : (state_q == ST_LOAD_A ? ST_LOAD_B : AFTER_B);
               valid_d = last && state_q == ST_LOAD_B && AFTER_B == ST_DONE;
            end
         end
`ifdef FRAME_CHECKSUM_EN
         ST_CHECK: begin
            if (bus.i_valid) begin
               state_d = csum_ok ? ST_DONE : ST_IDLE;
               valid_d = csum_ok;
               err_d   = !csum_ok;
            end
         end
`endif
         default: ;
      endcase
      if (expired && !bus.i_valid) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
         mat_a_q <= '{default: '0};
         mat_b_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
         if (bus.i_valid && state_q == ST_LOAD_A) mat_a_q[idx_q] <= bus.i_data;
         if (bus.i_valid && state_q == ST_LOAD_B) mat_b_q[idx_q] <= bus.i_data;
      end
   assign bus.o_mat_a   = mat_a_q;
   assign bus.o_mat_b   = mat_b_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_busy    = loading;
   assign bus.o_err     = err_q;
   assign bus.o_overrun = ovr_q;
endmodule
